branch_history_table: RTL



---
 rtl/bht_pkg.sv | 39 +++
 rtl/bht_entry_next.sv | 38 +++
 rtl/branch_history_table.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table.
// Entry payload: [9:8] local history h, [2i+1:2i] saturating counter Ci.
package bht_pkg;

    localparam int PARA_W  = 10;
    localparam int TAG_W   = 24;
    localparam int HIST_HI = 9;
    localparam int HIST_LO = 8;
    localparam int CNT_W   = 2;
    localparam int NUM_CNT = 4;
    localparam int ENTRY_W = 1 + TAG_W + PARA_W;

    localparam logic [CNT_W-1:0] CNT_WNT = 2'b01;
    localparam logic [CNT_W-1:0] CNT_WT  = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bht_state_t;

    typedef struct packed {
        logic               valid;
        logic [TAG_W-1:0]   tag;
        logic [PARA_W-1:0]  para;
    } bht_entry_t;

    // Two-bit saturating step: up counts towards 3, down towards 0.
    function automatic logic [CNT_W-1:0] sat2(input logic [CNT_W-1:0] cnt, input logic up);
        logic [CNT_W-1:0] r;
        r = cnt;
        if (up) begin
            if (cnt != 2'b11) r = cnt + 2'd1;
        end else begin
            if (cnt != 2'b00) r = cnt - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bht_entry_next.sv
// Next-entry computation for one table slot: trains a hit, allocates on a miss.
module bht_entry_next
    import bht_pkg::*;
(
    input  logic [ENTRY_W-1:0] old_entry,
    input  logic               hit,
    input  logic [TAG_W-1:0]   tag,
    input  logic               taken,
    output logic [ENTRY_W-1:0] new_entry
);

    bht_entry_t old_e;
    bht_entry_t nxt_e;
    logic [1:0] hist;

    assign old_e     = bht_entry_t'(old_entry);
    assign hist      = old_e.para[HIST_HI:HIST_LO];
    assign new_entry = nxt_e;

    // Hit: step only the counter selected by history, then shift history.
    // Miss: fresh entry with every counter weakly biased towards the outcome.
    always_comb begin
        nxt_e = old_e;
        if (hit) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (hist == 2'(i)) begin
                    nxt_e.para[i*CNT_W +: CNT_W] = sat2(old_e.para[i*CNT_W +: CNT_W], taken);
                end
            end
            nxt_e.para[HIST_HI:HIST_LO] = {hist[0], taken};
        end else begin
            nxt_e.valid = 1'b1;
            nxt_e.tag   = tag;
            nxt_e.para  = {1'b0, taken, {NUM_CNT{taken ? CNT_WT : CNT_WNT}}};
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Pattern-history table: two slots per set (slot = pc[2]), combinational
// lookup for the fetch pair at pc_now, one-register update stage (U1) fed by
// execute-stage branch resolutions, and an index sweep that clears the table
// after reset.
// Optional feature: define BHT_BYPASS_EN to forward the U1 write into a
// same-cycle lookup of the same slot.
// Handshake: an execute resolution is accepted on a cycle where
// en & ex_vld & ready; it is dropped otherwise (no back-pressure).
// fsm_state exposes the sweep/run state (0 = CLEAR, 1 = RUN) for debug.
module branch_history_table
    import bht_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int HASH_DEPTH = 5,
    parameter int HASH_WIDTH = 24,
    parameter int PARA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] pc_now,
    output logic                  past_vld1,
    output logic                  past_vld2,
    output logic [PARA_WIDTH-1:0] past1,
    output logic [PARA_WIDTH-1:0] past2,
    input  logic                  ex_vld,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  ex_taken,
    output logic                  ready,
    output logic                  fsm_state
);

    localparam int SETS = 1 << HASH_DEPTH;

    // The payload layout is fixed; the entry type also pins the tag width.
    if (PARA_WIDTH != PARA_W) begin : g_para_width_check
        $error("branch_history_table: PARA_WIDTH must be 10");
    end
    if (HASH_WIDTH != TAG_W) begin : g_tag_width_check
        $error("branch_history_table: HASH_WIDTH must match bht_pkg::TAG_W");
    end

    bht_state_t             state_q, state_d;
    logic [HASH_DEPTH-1:0]  clr_idx;
    logic                   clr_en;

    logic                   u1_vld;
    logic [HASH_DEPTH-1:0]  u1_idx;
    logic                   u1_slot;
    logic [HASH_WIDTH-1:0]  u1_tag;
    logic                   u1_taken;

    bht_entry_t             tbl_q [SETS][2];
    bht_entry_t             u1_old;
    bht_entry_t             u1_new;
    logic [ENTRY_W-1:0]     u1_new_bits;
    logic                   u1_hit;
    logic                   capture;

    logic [HASH_DEPTH-1:0]  lk_idx;
    logic [HASH_WIDTH-1:0]  lk_tag;
    bht_entry_t             lk_e [2];
    logic [1:0]             lk_hit;

    logic                   unused_pc_bits;

    assign lk_idx         = pc_now[HASH_DEPTH+2:3];
    assign lk_tag         = pc_now[HASH_WIDTH+HASH_DEPTH+2:HASH_DEPTH+3];
    assign capture        = en & ex_vld & ready;
    assign fsm_state      = state_q;
    assign unused_pc_bits = ^{pc_now[2:0], ex_pc[1:0]};

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= ST_CLEAR;
        else       state_q <= state_d;
    end

    // Next state: leave CLEAR once the last set has been cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_idx == {HASH_DEPTH{1'b1}}) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // State outputs: table is usable only in RUN; CLEAR drives the sweep.
    always_comb begin
        ready  = 1'b0;
        clr_en = 1'b0;
        case (state_q)
            ST_CLEAR: clr_en = 1'b1;
            ST_RUN:   ready  = 1'b1;
            default:  clr_en = 1'b1;
        endcase
    end

    // Sweep index: walks every set once while clearing.
    always_ff @(posedge clk) begin
        if (!rstn)       clr_idx <= '0;
        else if (clr_en) clr_idx <= clr_idx + HASH_DEPTH'(1);
    end

    // U1 capture: one pending update; discarded by reset, never loaded in CLEAR.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            u1_vld   <= 1'b0;
            u1_idx   <= '0;
            u1_slot  <= 1'b0;
            u1_tag   <= '0;
            u1_taken <= 1'b0;
        end else begin
            u1_vld <= capture;
            if (capture) begin
                u1_idx   <= ex_pc[HASH_DEPTH+2:3];
                u1_slot  <= ex_pc[2];
                u1_tag   <= ex_pc[HASH_WIDTH+HASH_DEPTH+2:HASH_DEPTH+3];
                u1_taken <= ex_taken;
            end
        end
    end

    // U1 reads the committed entry, so consecutive updates chain correctly.
    assign u1_old = tbl_q[u1_idx][u1_slot];
    assign u1_hit = u1_old.valid && (u1_old.tag == u1_tag);
    assign u1_new = bht_entry_t'(u1_new_bits);

    bht_entry_next u_entry_next (
        .old_entry (u1_old),
        .hit       (u1_hit),
        .tag       (u1_tag),
        .taken     (u1_taken),
        .new_entry (u1_new_bits)
    );

    // Table storage: sweep clears valid bits; U1 writes one slot. A reset
    // edge suppresses both so a pending update is lost, not committed.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (clr_en) begin
                tbl_q[clr_idx][0].valid <= 1'b0;
                tbl_q[clr_idx][1].valid <= 1'b0;
            end else if (u1_vld) begin
                tbl_q[u1_idx][u1_slot] <= u1_new;
            end
        end
    end

    // Lookup: read both slots of the set, optionally forwarding the U1 write.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            lk_e[s] = tbl_q[lk_idx][s];
`ifdef BHT_BYPASS_EN
            if (u1_vld && (u1_idx == lk_idx) && (u1_slot == 1'(s))) begin
                lk_e[s] = u1_new;
            end
`endif
            lk_hit[s] = ready && lk_e[s].valid && (lk_e[s].tag == lk_tag);
        end
    end

    assign past_vld1 = lk_hit[0];
    assign past_vld2 = lk_hit[1];
    assign past1     = lk_hit[0] ? lk_e[0].para : '0;
    assign past2     = lk_hit[1] ? lk_e[1].para : '0;

endmodule
